// File: rtl/serial_frame_comparator.sv
// Serial frame comparator: streams (a, b) bit pairs, tests a xnor b per bit and reports match,
// mismatch count and first-mismatch index per frame. Optional macro SFC_EARLY_EXIT_EN ends a frame at its first mismatch.
module serial_frame_comparator #(
    parameter  int FRAME_LEN = 8,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1),
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [IDX_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [CNT_W-1:0]   run_cnt_r;
    logic [IDX_W-1:0]   run_first_idx_r;
    logic               run_first_seen_r;

    logic               transfer_s;
    logic               mism_s;
    logic               last_s;
    logic               early_s;
    logic               finish_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [IDX_W-1:0]   first_idx_next_s;
    logic               first_seen_next_s;

    function automatic logic bit_eq(input logic x, input logic y);
        return x ~^ y;
    endfunction

    // Per-transfer arithmetic; abort masks the transfer so nothing it carried is ever counted.
    always_comb begin
        transfer_s        = in_valid && (state_r == COMPARE) && !abort;
        mism_s            = !bit_eq(a, b);
        last_s            = (bit_idx_r == IDX_W'(FRAME_LEN - 1));
        cnt_next_s        = run_cnt_r + {{(CNT_W-1){1'b0}}, mism_s};
        first_seen_next_s = run_first_seen_r | mism_s;
        if (mism_s && !run_first_seen_r) begin
            first_idx_next_s = bit_idx_r;
        end else begin
            first_idx_next_s = run_first_idx_r;
        end
`ifdef SFC_EARLY_EXIT_EN
        early_s           = mism_s;
`else
        early_s           = 1'b0;
`endif
        finish_s          = transfer_s && (last_s || early_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort wins over frame completion.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = COMPARE;
                else       state_s = IDLE;
            end
            COMPARE: begin
                if (abort)         state_s = IDLE;
                else if (finish_s) state_s = DONE;
                else               state_s = COMPARE;
            end
            DONE: begin
                if (start) state_s = COMPARE;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode straight from the registered state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            COMPARE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Running frame accumulators, cleared whenever a new frame is launched from IDLE or DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_r        <= {IDX_W{1'b0}};
            run_cnt_r        <= {CNT_W{1'b0}};
            run_first_idx_r  <= {IDX_W{1'b0}};
            run_first_seen_r <= 1'b0;
        end else if ((state_r != COMPARE) && start) begin
            bit_idx_r        <= {IDX_W{1'b0}};
            run_cnt_r        <= {CNT_W{1'b0}};
            run_first_idx_r  <= {IDX_W{1'b0}};
            run_first_seen_r <= 1'b0;
        end else if (transfer_s) begin
            bit_idx_r        <= bit_idx_r + IDX_W'(1);
            run_cnt_r        <= cnt_next_s;
            run_first_idx_r  <= first_idx_next_s;
            run_first_seen_r <= first_seen_next_s;
        end else begin
            bit_idx_r        <= bit_idx_r;
            run_cnt_r        <= run_cnt_r;
            run_first_idx_r  <= run_first_idx_r;
            run_first_seen_r <= run_first_seen_r;
        end
    end

    // Result registers take the final values, last bit included, on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match         <= 1'b0;
            err_cnt       <= {CNT_W{1'b0}};
            first_err_vld <= 1'b0;
            first_err_idx <= {IDX_W{1'b0}};
        end else if (finish_s) begin
            match         <= (cnt_next_s == {CNT_W{1'b0}});
            err_cnt       <= cnt_next_s;
            first_err_vld <= first_seen_next_s;
            first_err_idx <= first_idx_next_s;
        end else begin
            match         <= match;
            err_cnt       <= err_cnt;
            first_err_vld <= first_err_vld;
            first_err_idx <= first_err_idx;
        end
    end

endmodule

// File: tb/tb_serial_frame_comparator.sv
// Randomized and directed bench for serial_frame_comparator against a frame-level reference model.
module tb_serial_frame_comparator;

    localparam int FL    = 8;
    localparam int CNT_W = $clog2(FL + 1);
    localparam int IDX_W = $clog2(FL);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             match;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [IDX_W-1:0] first_err_idx;

    int n_checks = 0;
    int n_errors = 0;

    int exp_match = 0;
    int exp_cnt   = 0;
    int exp_vld   = 0;
    int exp_idx   = 0;

    serial_frame_comparator #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .busy(busy), .done(done), .match(match), .err_cnt(err_cnt),
        .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Frame-level expectation: count of differing bit positions, lowest differing position,
    // and how many bits the block will consume.
    task automatic model(input logic [FL-1:0] av, input logic [FL-1:0] bv,
                         output int cnt, output int idx, output int vld, output int n);
        logic [FL-1:0] diff;
        diff = av ^ bv;
        cnt = 0; idx = 0; vld = 0; n = FL;
        for (int i = 0; i < FL; i++) begin
            if (diff[i] && vld == 0) begin
                vld = 1;
                idx = i;
`ifdef SFC_EARLY_EXIT_EN
                n = i + 1;
`endif
            end
            if (diff[i] && i < n) cnt++;
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_match"}, match, exp_match);
        check({tag, "_err_cnt"}, err_cnt, exp_cnt);
        check({tag, "_first_vld"}, first_err_vld, exp_vld);
        check({tag, "_first_idx"}, first_err_idx, exp_idx);
    endtask

    // Drives one frame from a negedge; optionally already launched, optionally chains the next start.
    task automatic run_frame(input string tag, input logic [FL-1:0] av, input logic [FL-1:0] bv,
                             input bit toggle, input bit started, input bit chain);
        int ecnt, eidx, evld, n, idx, cyc;
        bit rdy, early_done, held_bad;
        model(av, bv, ecnt, eidx, evld, n);
        if (!started) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready"}, in_ready, 1);
        idx = 0; cyc = 0; early_done = 0; held_bad = 0;
        while (idx < n && cyc < 4 * FL) begin
            rdy = in_ready;
            if (done) early_done = 1;
            if (match !== exp_match[0] || err_cnt !== CNT_W'(exp_cnt)) held_bad = 1;
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            a = av[idx];
            b = bv[idx];
            @(negedge clk);
            if (in_valid && rdy) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_consumed"}, idx, n);
        check({tag, "_no_early_done"}, early_done, 0);
        check({tag, "_held_prev"}, held_bad, 0);
        check({tag, "_latency"}, cyc, toggle ? 2 * n - 1 : n);
        check({tag, "_done"}, done, 1);
        check({tag, "_ready_in_done"}, in_ready, 0);
        exp_match = (ecnt == 0);
        exp_cnt   = ecnt;
        exp_vld   = evld;
        exp_idx   = eidx;
        check_results(tag);
        if (chain) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, chain ? 1 : 0);
        check_results({tag, "_hold"});
    endtask

    initial begin
        logic [FL-1:0] ra, rb;
        bit saw_done;

        #3;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check_results("rst");
        @(negedge clk);
        rst_n = 1'b1;
        // in_valid and abort in IDLE must do nothing
        in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_done", done, 0);
        in_valid = 1'b0; abort = 1'b0;

        run_frame("eq_a5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
        run_frame("ff_f0", 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_frame("msb_toggle", 8'h00, 8'h80, 1'b1, 1'b0, 1'b0);

        // abort after 3 transfers, with a transfer offered in the abort cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 1'b0; b = 1'b0;
            @(negedge clk);
        end
        abort = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy", busy, 0);
        saw_done = done;
        @(negedge clk);
        saw_done = saw_done | done;
        check("abort_no_done", saw_done, 0);
        check_results("abort");

        // back-to-back frames: second starts from DONE without IDLE
        run_frame("b2b_first", 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
        run_frame("b2b_second", 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            ra = FL'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : FL'($urandom);
            run_frame($sformatf("rand%0d", k), ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // asynchronous reset between clock edges in mid-frame
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a = 1'b1; b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_done", done, 0);
        exp_match = 0; exp_cnt = 0; exp_vld = 0; exp_idx = 0;
        check_results("arst");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < FL + 2; i++) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        in_valid = 1'b0;
        check("arst_stays_idle", saw_done, 0);

        run_frame("post_rst", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
